// File: rtl/div_scheduler.sv
// Round-robin scheduler sharing one sequential 8-bit-quotient divider among N_REQ requesters.
// Jobs are granted in IDLE, issued with a one-cycle div_flag, and the quotient is returned after a fixed wait.
module div_scheduler #(
   parameter  int unsigned N_REQ       = 4,
   parameter  int unsigned DIV_LATENCY = 12,
   localparam int unsigned DATA_W      = 16,
   localparam int unsigned Q_W         = 8
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [N_REQ-1:0]        req,
   input  logic [DATA_W*N_REQ-1:0] req_dividend,
   input  logic [DATA_W*N_REQ-1:0] req_divisor,
   output logic [N_REQ-1:0]        ack,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [Q_W*N_REQ-1:0]    rsp_quotient,
   output logic                    busy,
   output logic                    div_flag,
   output logic [DATA_W-1:0]       div_count,
   output logic [DATA_W-1:0]       div_divider,
   input  logic [Q_W-1:0]          div_q
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);
   localparam logic [Q_W-1:0] ZERO_DIV_Q = '1;

   typedef struct packed {
      logic [DATA_W-1:0] dividend;
      logic [DATA_W-1:0] divisor;
   } job_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   grant_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               zero_q;
   job_t               op_q;

   logic               grant_found;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   arb_rot;
   logic [IDX_W-1:0]   ptr_next;
   job_t               job_sel;
   logic               grant_load;
   logic               rsp_load;
   logic [N_REQ-1:0]   ack_d;
   logic [N_REQ-1:0]   rsp_valid_d;
   logic               flag_d;

   // Round-robin search: first set req bit at or above the pointer, wrapping at N_REQ-1.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      arb_rot     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         arb_rot = IDX_W'((32'(ptr_q) + 32'(k)) % N_REQ);
         if (!grant_found && req[arb_rot]) begin
            grant_found = 1'b1;
            grant_idx   = arb_rot;
         end
      end
   end

   always_comb begin
      job_sel.dividend = req_dividend[DATA_W*grant_idx +: DATA_W];
      job_sel.divisor  = req_divisor[DATA_W*grant_idx +: DATA_W];
      ptr_next         = IDX_W'((32'(grant_idx) + 32'd1) % N_REQ);
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_load  = 1'b0;
      rsp_load    = 1'b0;
      ack_d       = '0;
      rsp_valid_d = '0;
      flag_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               grant_load       = 1'b1;
               ack_d[grant_idx] = 1'b1;
               if (job_sel.divisor != '0) begin
                  state_d = ISSUE;
                  flag_d  = 1'b1;
               end else begin
                  state_d = CAPTURE;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_LATENCY - 1)) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            rsp_load             = 1'b1;
            rsp_valid_d[grant_q] = 1'b1;
            state_d              = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         grant_q      <= '0;
         cnt_q        <= '0;
         zero_q       <= 1'b0;
         op_q         <= '0;
         ack          <= '0;
         rsp_valid    <= '0;
         rsp_quotient <= '0;
         busy         <= 1'b0;
         div_flag     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack       <= ack_d;
         rsp_valid <= rsp_valid_d;
         div_flag  <= flag_d;
         busy      <= (state_d != IDLE);
         if (grant_load) begin
            op_q    <= job_sel;
            grant_q <= grant_idx;
            ptr_q   <= ptr_next;
            zero_q  <= (job_sel.divisor == '0);
         end
         // A zero divisor never starts the divider; its slot gets the saturated quotient.
         if (rsp_load) begin
            rsp_quotient[Q_W*grant_q +: Q_W] <= zero_q ? ZERO_DIV_Q : div_q;
         end
      end
   end

   // Operands stay on the divider bus from grant until the next grant.
   assign div_count   = op_q.dividend;
   assign div_divider = op_q.divisor;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: two instances (latency 12 and the minimum 10), each with a divider stub,
// checked every cycle against a job-timeline model plus directed literal expectations.
module tb_div_scheduler;

   localparam int N  = 4;
   localparam int NL = 2;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   logic [N-1:0]    req [NL];
   logic [16*N-1:0] dvd [NL];
   logic [16*N-1:0] dvs [NL];
   wire  [N-1:0]    ack [NL];
   wire  [N-1:0]    rv  [NL];
   wire  [8*N-1:0]  q   [NL];
   wire             busy [NL];
   wire             flag [NL];
   wire  [15:0]     cnt [NL];
   wire  [15:0]     dvr [NL];
   logic [7:0]      dq  [NL];

   div_scheduler #(.N_REQ(N), .DIV_LATENCY(12)) u_dut0 (
      .clk(clk), .nrst(nrst), .req(req[0]), .req_dividend(dvd[0]), .req_divisor(dvs[0]),
      .ack(ack[0]), .rsp_valid(rv[0]), .rsp_quotient(q[0]), .busy(busy[0]), .div_flag(flag[0]),
      .div_count(cnt[0]), .div_divider(dvr[0]), .div_q(dq[0]));

   div_scheduler #(.N_REQ(N), .DIV_LATENCY(10)) u_dut1 (
      .clk(clk), .nrst(nrst), .req(req[1]), .req_dividend(dvd[1]), .req_divisor(dvs[1]),
      .ack(ack[1]), .rsp_valid(rv[1]), .rsp_quotient(q[1]), .busy(busy[1]), .div_flag(flag[1]),
      .div_count(cnt[1]), .div_divider(dvr[1]), .div_q(dq[1]));

   // Divider stub: result = dividend[7:0] + divisor[7:0], visible 11 cycles after the div_flag cycle.
   int         scnt [NL];
   logic [7:0] sres [NL];
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int l = 0; l < NL; l++) begin
            scnt[l] <= 0;
            sres[l] <= 8'h00;
            dq[l]   <= 8'h00;
         end
      end else begin
         for (int l = 0; l < NL; l++) begin
            if (flag[l]) begin
               scnt[l] <= 1;
               sres[l] <= cnt[l][7:0] + dvr[l][7:0];
            end else if (scnt[l] == 10) begin
               dq[l]   <= sres[l];
               scnt[l] <= 0;
            end else if (scnt[l] != 0) begin
               scnt[l] <= scnt[l] + 1;
            end
         end
      end
   end

   // Job-timeline model: t counts cycles since the sampling edge of the current job.
   typedef struct packed {
      logic        in_job;
      logic        zero;
      logic [1:0]  g;
      logic [1:0]  ptr;
      int          t;
      logic [15:0] dvd;
      logic [15:0] dvs;
      logic [31:0] q;
      logic [3:0]  ack;
      logic [3:0]  rv;
      logic        flag;
   } mdl_t;

   mdl_t m [NL];

   function automatic int lat_of(input int l);
      return (l == 0) ? 12 : 10;
   endfunction

   function automatic mdl_t step(input mdl_t cur, input logic [3:0] r, input logic [63:0] a,
                                 input logic [63:0] b, input int lat);
      mdl_t nx;
      int   g;
      int   idx;
      nx      = cur;
      nx.ack  = 4'b0;
      nx.rv   = 4'b0;
      nx.flag = 1'b0;
      g       = -1;
      if (!cur.in_job) begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(cur.ptr) + k) % N;
            if (g < 0 && r[idx]) g = idx;
         end
         if (g >= 0) begin
            nx.in_job = 1'b1;
            nx.t      = 1;
            nx.g      = 2'(g);
            nx.ptr    = 2'((g + 1) % N);
            nx.dvd    = a[16*g +: 16];
            nx.dvs    = b[16*g +: 16];
            nx.zero   = (b[16*g +: 16] == 16'h0000);
            nx.ack[g] = 1'b1;
            nx.flag   = (b[16*g +: 16] != 16'h0000);
         end
      end else begin
         nx.t = cur.t + 1;
         if (cur.zero ? (nx.t == 2) : (nx.t == lat + 3)) begin
            nx.in_job         = 1'b0;
            nx.rv[cur.g]      = 1'b1;
            nx.q[8*cur.g +: 8] = cur.zero ? 8'hFF : (cur.dvd[7:0] + cur.dvs[7:0]);
         end
      end
      return nx;
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int l = 0; l < NL; l++) m[l] <= '0;
      end else begin
         for (int l = 0; l < NL; l++) m[l] <= step(m[l], req[l], dvd[l], dvs[l], lat_of(l));
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int glog [$];
   int gcyc [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic chk_ge(input string name, input int got, input int lim);
      n_checks++;
      if (got < lim) begin
         n_fail++;
         $display("FAIL %s: got %0d expected at least %0d (cycle %0d)", name, got, lim, cyc);
      end
   endtask

   task automatic cmp_lane(input int l);
      logic [73:0] a;
      logic [73:0] e;
      a = {ack[l], rv[l], busy[l], flag[l], q[l], cnt[l], dvr[l]};
      e = {m[l].ack, m[l].rv, m[l].in_job, m[l].flag, m[l].q, m[l].dvd, m[l].dvs};
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL lane%0d_outputs cycle %0d: got %h expected %h", l, cyc, a, e);
      end
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // One cycle: compare both lanes, log lane-0 grants, requesters drop req on ack.
   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int l = 0; l < NL; l++) cmp_lane(l);
      if (ack[0] != 4'b0) begin
         glog.push_back(onehot_idx(ack[0]));
         gcyc.push_back(cyc);
      end
      for (int l = 0; l < NL; l++) req[l] = req[l] & ~ack[l];
   endtask

   task automatic wait_idle(input int l, input int max);
      int k;
      k = 0;
      while (busy[l] && k < max) begin
         tick();
         k++;
      end
      n_checks++;
      if (busy[l]) begin
         n_fail++;
         $display("FAIL idle_timeout lane%0d: busy still 1 after %0d cycles", l, max);
      end
   endtask

   initial begin
      int fexp [5];
      fexp = '{0, 1, 2, 3, 0};
      nrst = 1'b0;
      for (int l = 0; l < NL; l++) begin
         req[l] = '0;
         dvd[l] = '0;
         dvs[l] = '0;
      end
      repeat (3) tick();
      for (int l = 0; l < NL; l++) begin
         chk("reset_ack_rv", 32'({ack[l], rv[l]}), 32'h0);
         chk("reset_quot", q[l], 32'h0);
         chk("reset_busy_flag", 32'({busy[l], flag[l]}), 32'h0);
         chk("reset_operands", {cnt[l], dvr[l]}, 32'h0);
      end
      nrst = 1'b1;
      tick();

      // Single job on requester 2.
      dvd[0][47:32] = 16'h0010;
      dvs[0][47:32] = 16'h0003;
      req[0][2]     = 1'b1;
      tick();
      chk("t1_ack", 32'(ack[0]), 32'h4);
      chk("t1_flag", 32'(flag[0]), 32'h1);
      chk("t1_count", 32'(cnt[0]), 32'h0010);
      chk("t1_divider", 32'(dvr[0]), 32'h0003);
      repeat (13) tick();
      chk("t1_rv_early", 32'(rv[0]), 32'h0);
      tick();
      chk("t1_rv", 32'(rv[0]), 32'h4);
      chk("t1_quot", q[0], 32'h0013_0000);

      // Zero divisor bypass on requester 1.
      dvd[0][31:16] = 16'h1234;
      dvs[0][31:16] = 16'h0000;
      req[0][1]     = 1'b1;
      tick();
      chk("zd_ack", 32'(ack[0]), 32'h2);
      chk("zd_flag", 32'(flag[0]), 32'h0);
      tick();
      chk("zd_rv", 32'(rv[0]), 32'h2);
      chk("zd_quot", q[0], 32'h0013_FF00);

      // Requester 3 arrives mid-job of requester 0; operands as of grant are used.
      dvd[0][15:0] = 16'h1234;
      dvs[0][15:0] = 16'h0005;
      req[0][0]    = 1'b1;
      tick();
      chk("ov_ack0", 32'(ack[0]), 32'h1);
      repeat (2) tick();
      dvd[0][63:48] = 16'hAAAA;
      dvs[0][63:48] = 16'h0011;
      req[0][3]     = 1'b1;
      repeat (3) tick();
      dvd[0][63:48] = 16'hBB07;
      dvs[0][63:48] = 16'h0009;
      repeat (9) tick();
      chk("ov_rv0", 32'(rv[0]), 32'h1);
      chk("ov_quot0", q[0], 32'h0013_FF39);
      tick();
      chk("ov_ack3", 32'(ack[0]), 32'h8);
      chk("ov_flag3", 32'(flag[0]), 32'h1);
      chk("ov_count3", {cnt[0], dvr[0]}, 32'hBB07_0009);
      dvd[0][63:48] = 16'hCCCC;
      dvs[0][63:48] = 16'h0001;
      tick();
      chk("ov_count_held", {cnt[0], dvr[0]}, 32'hBB07_0009);
      repeat (13) tick();
      chk("ov_rv3", 32'(rv[0]), 32'h8);
      chk("ov_quot3", q[0], 32'h1013_FF39);

      // Reset in the middle of WAIT.
      dvd[0][47:32] = 16'h0042;
      dvs[0][47:32] = 16'h0021;
      req[0][2]     = 1'b1;
      repeat (5) tick();
      #2 nrst = 1'b0;
      #1;
      for (int l = 0; l < NL; l++) begin
         chk("async_rst_ctl", 32'({ack[l], rv[l], busy[l], flag[l]}), 32'h0);
         chk("async_rst_quot", q[l], 32'h0);
         chk("async_rst_ops", {cnt[l], dvr[l]}, 32'h0);
         req[l] = '0;
      end
      repeat (3) tick();
      nrst = 1'b1;

      // Fairness right after reset: all requesters continuously re-request.
      dvd[0] = 64'h0004_0003_0002_0001;
      dvs[0] = 64'h0010_0010_0010_0010;
      glog.delete();
      gcyc.delete();
      req[0] = 4'hF;
      for (int k = 0; k < 100 && glog.size() < 5; k++) begin
         tick();
         req[0] = 4'hF & ~ack[0];
      end
      req[0] = 4'h0;
      for (int i = 0; i < 5; i++) begin
         chk("fair_grant", 32'((i < glog.size()) ? glog[i] : 99), 32'(fexp[i]));
      end
      for (int i = 1; i < 5; i++) begin
         chk_ge("fair_spacing", (i < gcyc.size()) ? gcyc[i] - gcyc[i-1] : 0, 15);
      end
      wait_idle(0, 40);
      chk("fair_quot", q[0], 32'h1413_1211);

      // Boundary instance: latency 10 against an 11-cycle divider.
      dvd[1][31:16] = 16'h00A0;
      dvs[1][31:16] = 16'h0007;
      req[1][1]     = 1'b1;
      tick();
      chk("b10_ack", 32'(ack[1]), 32'h2);
      repeat (11) tick();
      chk("b10_rv_early", 32'(rv[1]), 32'h0);
      tick();
      chk("b10_rv", 32'(rv[1]), 32'h2);
      chk("b10_quot", q[1], 32'h0000_A700);

      // Randomized traffic on both instances.
      for (int c = 0; c < 2000; c++) begin
         tick();
         for (int l = 0; l < NL; l++) begin
            for (int i = 0; i < N; i++) begin
               if (!req[l][i] && !ack[l][i]) begin
                  if ($urandom_range(0, 3) == 0) begin
                     dvd[l][16*i +: 16] = 16'($urandom);
                     dvs[l][16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                  end
                  if ($urandom_range(0, 5) == 0) req[l][i] = 1'b1;
               end else if ($urandom_range(0, 9) == 0) begin
                  dvd[l][16*i +: 16] = 16'($urandom);
                  dvs[l][16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
               end
            end
         end
      end
      for (int l = 0; l < NL; l++) req[l] = '0;
      wait_idle(0, 40);
      wait_idle(1, 40);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
